// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the register-bank pipeline issuer.
// Holds the instruction word layout, func codes and the issuer FSM state type.
package pipe_pkg;

  localparam int unsigned INSTR_W = 24;
  localparam int unsigned FUNC_W  = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned STALL_W = 16;

  // Bit offsets of each field inside the 24-bit instruction word
  localparam int unsigned FUNC_LSB = 20;
  localparam int unsigned RD_LSB   = 16;
  localparam int unsigned RS1_LSB  = 12;
  localparam int unsigned RS2_LSB  = 8;
  localparam int unsigned ADDR_LSB = 0;

  typedef logic [FUNC_W-1:0] func_t;

  localparam func_t FN_ADD   = 4'h0;
  localparam func_t FN_SUB   = 4'h1;
  localparam func_t FN_MUL   = 4'h3;
  localparam func_t FN_PASSA = 4'h4;
  localparam func_t FN_PASSB = 4'h5;
  localparam func_t FN_AND   = 4'h6;
  localparam func_t FN_OR    = 4'h7;
  localparam func_t FN_XOR   = 4'h8;
  localparam func_t FN_NEGA  = 4'h9;
  localparam func_t FN_NEGB  = 4'hA;
  localparam func_t FN_SHR   = 4'hB;
  localparam func_t FN_SHL   = 4'hC;
  localparam func_t FN_HALT  = 4'hF;

  // Packed layout mirrors the word: func[23:20] rd[19:16] rs1[15:12] rs2[11:8] addr[7:0]
  typedef struct packed {
    func_t             func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: 2-deep {valid, rd} history of the last two issue slots
// and the read-after-write comparators for the next instruction.
// Ports: clk, rst_n; i_clear (new program), i_shift (one issue slot elapsed),
//        i_push_valid/i_push_rd (slot content), i_rs1/i_rs2 (candidate sources),
//        o_hazard_c (combinational: a source matches an in-flight destination).
module pipe_scoreboard
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_push_valid,
  input  logic [REG_W-1:0] i_push_rd,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  output logic             o_hazard_c
);

  logic [1:0]       r_valid;   // [0] = newest slot
  logic [REG_W-1:0] r_rd0;
  logic [REG_W-1:0] r_rd1;
  logic             w_hit0;
  logic             w_hit1;

  // Shift history one slot per issue cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_rd0   <= '0;
      r_rd1   <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
      r_rd0   <= '0;
      r_rd1   <= '0;
    end else if (i_shift) begin
      r_valid <= {r_valid[0], i_push_valid};
      r_rd1   <= r_rd0;
      r_rd0   <= i_push_rd;
    end
  end

  assign w_hit0     = r_valid[0] && ((i_rs1 == r_rd0) || (i_rs2 == r_rd0));
  assign w_hit1     = r_valid[1] && ((i_rs1 == r_rd1) || (i_rs2 == r_rd1));
  assign o_hazard_c = w_hit0 || w_hit1;

endmodule

// File: rtl/pipe_issue.sv
// pipe_issue: program store + PC sequencer that issues one instruction per
// cycle into the four-stage register-bank pipeline, then drains and pulses done.
// Optional feature macro: PIPE_ISSUE_HAZARD_EN (scoreboard interlock + stall count).
// Ports: clk, rst_n; prog_we/prog_addr/prog_wdata (store load, idle only);
//        start (pulse); rs1/rs2/rd/func/addr + issue_valid (registered issue);
//        busy, done (pulse), stall_cnt (bubbles since last start, saturating).
module pipe_issue
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PC_W         = $clog2(DEPTH),
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic               start,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [REG_W-1:0]   rd,
  output logic [FUNC_W-1:0]  func,
  output logic [ADDR_W-1:0]  addr,
  output logic               issue_valid,
  output logic               busy,
  output logic               done,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

  instr_t           r_store [DEPTH];
  state_e           r_state,   w_state_nxt;
  logic [PC_W-1:0]  r_pc,      w_pc_nxt;
  instr_t           r_out,     w_out_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_done,    w_done_nxt;
  logic [DRN_W-1:0] r_drain,   w_drain_nxt;
  instr_t           w_word;
  logic             w_start_acc;
  logic             w_hazard;
  logic             w_shift;
  logic             w_push_v;
  logic             w_clear;
  logic             w_stall_inc;

  // Program store: no reset, loads dropped while a program runs
  always_ff @(posedge clk) begin
    if (prog_we && !r_busy) r_store[prog_addr] <= instr_t'(prog_wdata);
  end

  assign w_word = r_store[r_pc];
  // A start landing on the done cycle is ignored
  assign w_start_acc = start && (r_state == ST_IDLE) && !r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Next state and next registered outputs; non-issue cycles drive zero fields
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_out_nxt   = '0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_drain_nxt = r_drain;
    w_shift     = 1'b0;
    w_push_v    = 1'b0;
    w_clear     = 1'b0;
    w_stall_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = '0;
          w_busy_nxt  = 1'b1;
          w_clear     = 1'b1;
        end
      end
      ST_RUN: begin
        w_shift = 1'b1;
        if (w_hazard) begin
          w_stall_inc = 1'b1;
        end else if (w_word.func == FN_HALT) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_out_nxt   = w_word;
          w_valid_nxt = 1'b1;
          w_push_v    = 1'b1;
          // Last entry is an implicit halt; the PC never wraps
          if (r_pc == PC_W'(DEPTH - 1)) begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = '0;
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (r_drain == DRN_W'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_drain_nxt = r_drain + DRN_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

`ifdef PIPE_ISSUE_HAZARD_EN
  logic [STALL_W-1:0] r_stall_cnt;

  pipe_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_shift      (w_shift),
    .i_push_valid (w_push_v),
    .i_push_rd    (w_word.rd),
    .i_rs1        (w_word.rs1),
    .i_rs2        (w_word.rs2),
    .o_hazard_c   (w_hazard)
  );

  // Bubble counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != {STALL_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  logic w_unused;

  assign w_hazard  = 1'b0;
  assign stall_cnt = '0;
  assign w_unused  = ^{w_shift, w_push_v, w_clear, w_stall_inc, w_word.rs1, w_word.rs2};
`endif

  assign func        = r_out.func;
  assign rd          = r_out.rd;
  assign rs1         = r_out.rs1;
  assign rs2         = r_out.rs2;
  assign addr        = r_out.addr;
  assign issue_valid = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_pipe_issue.sv
// tb_pipe_issue: scenario bench for pipe_issue; expected issue stream built by
// a small reference model into a queue and popped as the DUT issues.
module tb_pipe_issue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DRAIN = 3;
`ifdef PIPE_ISSUE_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif
  localparam logic [23:0] HALT_W = 24'hF00000;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [23:0] prog_wdata;
  logic        start;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        issue_valid, busy, done;
  logic [15:0] stall_cnt;

  typedef struct {
    logic [23:0] word;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_done_cyc;
  int          exp_stalls;
  logic [23:0] prog_img [DEPTH];
  int          errors = 0;
  int          checks = 0;

  pipe_issue #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .func       (func),
    .addr       (addr),
    .issue_valid(issue_valid),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [7:0] a);
    return {f, d, s1, s2, a};
  endfunction

  task automatic fill_halt;
    for (int i = 0; i < DEPTH; i++) prog_img[i] = HALT_W;
  endtask

  task automatic load_prog;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      prog_we    = 1'b1;
      prog_addr  = 4'(i);
      prog_wdata = prog_img[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Reference issue schedule: cycle 1 is the first slot after start is taken
  task automatic build_model;
    int          pc;
    int          cyc;
    logic [1:0]  sbv;
    logic [3:0]  sb0, sb1;
    logic [23:0] w;
    bit          haz;
    exp_q.delete();
    exp_stalls   = 0;
    exp_done_cyc = -1;
    pc  = 0;
    cyc = 0;
    sbv = 2'b00;
    sb0 = 4'h0;
    sb1 = 4'h0;
    for (int g = 0; g < 200; g++) begin
      cyc++;
      w   = prog_img[pc];
      haz = HAZ && ((sbv[0] && (w[15:12] == sb0 || w[11:8] == sb0)) ||
                    (sbv[1] && (w[15:12] == sb1 || w[11:8] == sb1)));
      if (haz) begin
        exp_stalls++;
        sbv = {sbv[0], 1'b0};
        sb1 = sb0;
      end else if (w[23:20] == 4'hF) begin
        exp_done_cyc = cyc + DRAIN;
        break;
      end else begin
        exp_q.push_back('{w, cyc});
        sbv = {sbv[0], 1'b1};
        sb1 = sb0;
        sb0 = w[19:16];
        if (pc == DEPTH - 1) begin
          exp_done_cyc = cyc + DRAIN;
          break;
        end
        pc++;
      end
    end
  endtask

  // Start the loaded program and score every cycle until done
  task automatic run_check(input string name, input bit corrupt, input bit ws_en,
                           input logic [23:0] ws_word);
    int          cyc;
    bit          finished;
    logic [23:0] got;
    exp_t        e;
    build_model();
    @(negedge clk);
    start = 1'b1;
    if (ws_en) begin
      prog_we    = 1'b1;
      prog_addr  = 4'h0;
      prog_wdata = ws_word;
    end
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    cyc      = 0;
    finished = 1'b0;
    while (!finished && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      got = {func, rd, rs1, rs2, addr};
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
      end
      if (issue_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_issue: cyc %0d word %h, none expected", name, cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e.word || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s issue: got %h at cyc %0d want %h at cyc %0d",
                     name, got, cyc, e.word, e.cyc);
          end
        end
      end else begin
        checks++;
        if (got !== 24'h0 || issue_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s bubble_fields: cyc %0d got %h v=%b want 000000 v=0",
                   name, cyc, got, issue_valid);
        end
      end
      if (done === 1'b1) begin
        finished = 1'b1;
        checks++;
        if (cyc != exp_done_cyc || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_timing: cyc %0d busy %b want cyc %0d busy 0",
                   name, cyc, busy, exp_done_cyc);
        end
        checks++;
        if (stall_cnt !== 16'(exp_stalls)) begin
          errors++;
          $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, exp_stalls);
        end
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL %s missing_issues: %0d left want 0", name, exp_q.size());
        end
      end
      if (corrupt && !finished) begin
        prog_we    = 1'b1;
        prog_addr  = 4'($urandom_range(0, DEPTH - 1));
        prog_wdata = 24'($urandom);
      end else begin
        prog_we = 1'b0;
      end
    end
    prog_we = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s done_timeout: no done within 200 cycles, want cyc %0d",
               name, exp_done_cyc);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({func, rd, rs1, rs2, addr} !== 24'h0 || issue_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL %s idle_outputs: fields %h v %b busy %b done %b stall %0d want all 0",
               name, {func, rd, rs1, rs2, addr}, issue_valid, busy, done, stall_cnt);
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    start      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = 4'h0;
    prog_wdata = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_independent;
    fill_halt();
    prog_img[0] = mk(4'h0, 4'h1, 4'h2, 4'h3, 8'h10);
    prog_img[1] = mk(4'h7, 4'h4, 4'h5, 4'h6, 8'h20);
    load_prog();
    run_check("independent", 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_raw_adjacent;
    fill_halt();
    prog_img[0] = mk(4'h0, 4'h1, 4'h2, 4'h3, 8'h11);
    prog_img[1] = mk(4'h1, 4'h2, 4'h1, 4'h3, 8'h22);
    load_prog();
    run_check("raw_adjacent", 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_raw_gap;
    fill_halt();
    prog_img[0] = mk(4'h0, 4'h1, 4'h2, 4'h3, 8'h01);
    prog_img[1] = mk(4'h8, 4'h7, 4'h8, 4'h9, 8'h02);
    prog_img[2] = mk(4'h6, 4'hA, 4'hB, 4'h1, 8'h03);
    load_prog();
    run_check("raw_gap", 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_full_store;
    for (int i = 0; i < DEPTH; i++)
      prog_img[i] = mk(4'(i % 13), 4'(i), 4'((i + 7) % 16), 4'((i + 11) % 16), 8'(i * 9 + 1));
    load_prog();
    run_check("full_store_wr_during_run", 1'b1, 1'b0, 24'h0);
    run_check("full_store_rerun", 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_write_with_start;
    fill_halt();
    prog_img[0] = mk(4'h0, 4'h1, 4'h2, 4'h3, 8'h10);
    prog_img[1] = mk(4'h7, 4'h4, 4'h5, 4'h6, 8'h20);
    load_prog();
    prog_img[0] = mk(4'hC, 4'h9, 4'hA, 4'hB, 8'h33);
    run_check("write_with_start", 1'b0, 1'b1, prog_img[0]);
  endtask

  task automatic test_start_on_done;
    // run_check returns at the negedge where done is high
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_on_done ignored: busy %b v %b want 0 0", busy, issue_valid);
    end
    run_check("start_after_done", 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_reset_mid_run;
    int n;
    int k;
    for (int i = 0; i < DEPTH; i++)
      prog_img[i] = mk(4'(i % 13), 4'((i * 3 + 1) % 16), 4'(15 - i), 4'(15 - i), 8'(i + 64));
    load_prog();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    k = 0;
    while (n < 3 && k < 100) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (issue_valid === 1'b1) n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL reset_mid_run issues_before_reset: got %0d want 3", n);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_run_async");
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_mid_run_held");
    rst_n = 1'b1;
    run_check("restart_after_reset", 1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw_adjacent();
    test_start_on_done();
    test_raw_gap();
    test_full_store();
    test_write_with_start();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
